// File: rtl/hazard_unit_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, control-hazard
// flush, a post-reset purge sequence and saturating hazard counters.
module hazard_unit_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic [1:0]       ResultSrc_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             PCSrc_E,
  input  logic             perf_clr,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             init_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              ICW       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0]  INIT_LOAD = ICW'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [ICW-1:0]   init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall;
  logic [1:0]       fwd_a, fwd_b;

  // M-stage result is younger than W-stage, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (rs != 5'd0 && RegWrite_M && rs == Rd_M)      return 2'b10;
    else if (rs != 5'd0 && RegWrite_W && rs == Rd_W) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign fwd_a    = fwd_sel(Rs1_E);
  assign fwd_b    = fwd_sel(Rs2_E);
  assign lw_stall = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                    ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    Stall_F    = 1'b1;
    Stall_D    = 1'b1;
    Flush_D    = 1'b1;
    Flush_E    = 1'b1;
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    init_busy  = 1'b1;
    if (state_q == S_RUN) begin
      Stall_F    = lw_stall;
      Stall_D    = lw_stall;
      Flush_D    = PCSrc_E;
      Flush_E    = lw_stall | PCSrc_E;
      ForwardA_E = fwd_a;
      ForwardB_E = fwd_b;
      init_busy  = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == '0) state_d = S_RUN;
        else                  init_cnt_d = init_cnt_q - ICW'(1);
      end
      S_RUN: begin
        if (perf_clr) begin
          stall_cnt_d = '0;
          flush_cnt_d = '0;
        end else begin
          if (lw_stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
          if (PCSrc_E && flush_cnt_q != CNT_MAX)  flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      init_cnt_q  <= INIT_LOAD;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit_ctrl.sv
// Scoreboard bench for hazard_unit_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_unit_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0]       ResultSrc_E;
  logic             RegWrite_M, RegWrite_W, PCSrc_E, perf_clr;
  logic             Stall_F, Stall_D, Flush_D, Flush_E, init_busy;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_unit_ctrl #(.INIT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .ResultSrc_E(ResultSrc_E),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .PCSrc_E(PCSrc_E),
    .perf_clr(perf_clr),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .init_busy(init_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] ctrl;   // {Stall_F, Stall_D, Flush_D, Flush_E}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    int         scnt;
    int         fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic stim_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".ctrl"}, 32'({Stall_F, Stall_D, Flush_D, Flush_E}), 32'(e.ctrl));
      check({e.name, ".fwdA"}, 32'(ForwardA_E), 32'(e.fa));
      check({e.name, ".fwdB"}, 32'(ForwardB_E), 32'(e.fb));
      check({e.name, ".busy"}, 32'(init_busy), 32'(e.busy));
      check({e.name, ".stall_cnt"}, 32'(stall_cnt), e.scnt);
      check({e.name, ".flush_cnt"}, 32'(flush_cnt), e.fcnt);
    end else if (stim_done) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst,
                       input logic [4:0] rs1d, input logic [4:0] rs2d,
                       input logic [4:0] rs1e, input logic [4:0] rs2e,
                       input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                       input logic [1:0] rsrc, input logic rwm, input logic rww,
                       input logic pcs, input logic clr);
    reset = rst;
    Rs1_D = rs1d; Rs2_D = rs2d; Rs1_E = rs1e; Rs2_E = rs2e;
    Rd_E = rde; Rd_M = rdm; Rd_W = rdw;
    ResultSrc_E = rsrc; RegWrite_M = rwm; RegWrite_W = rww;
    PCSrc_E = pcs; perf_clr = clr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load-use on Rs1_D==Rd_E==7, optional branch and clear.
  task automatic load_use(input logic rst, input logic pcs, input logic clr);
    drive(rst, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, pcs, clr);
  endtask

  task automatic expect_out(input string name, input logic [3:0] ctrl, input logic [1:0] fa,
                            input logic [1:0] fb, input logic busy, input int s, input int f);
    exp_t e;
    e.name = name; e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.busy = busy; e.scnt = s; e.fcnt = f;
    exp_q.push_back(e);
  endtask

  initial begin
    drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    step(); reset = 1'b1;
    expect_out("reset", 4'b1111, 2'b00, 2'b00, 1'b1, 0, 0);

    // Purge after release: four edges in INIT, hazards ignored and not counted.
    step(); idle();
    expect_out("init_e0", 4'b1111, 2'b00, 2'b00, 1'b1, 0, 0);
    step(); idle();
    expect_out("init_e1", 4'b1111, 2'b00, 2'b00, 1'b1, 0, 0);
    step(); drive(1'b0, 5'd7, 5'd0, 5'd5, 5'd0, 5'd7, 5'd5, 5'd0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("init_e2_hazard", 4'b1111, 2'b00, 2'b00, 1'b1, 0, 0);
    step(); idle();
    expect_out("init_e3", 4'b1111, 2'b00, 2'b00, 1'b1, 0, 0);
    step(); idle();
    expect_out("run_idle", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);

    // Forwarding.
    step(); drive(1'b0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("fwdA_M", 4'b0000, 2'b10, 2'b00, 1'b0, 0, 0);
    step(); drive(1'b0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("fwdA_W", 4'b0000, 2'b01, 2'b00, 1'b0, 0, 0);
    step(); drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("fwdA_x0", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);
    step(); drive(1'b0, 5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("fwd_AW_BM", 4'b0000, 2'b01, 2'b10, 1'b0, 0, 0);
    step(); drive(1'b0, 5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("fwd_both_M", 4'b0000, 2'b10, 2'b10, 1'b0, 0, 0);
    step(); drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd4, 5'd4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("fwdB_nowrite", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);

    // Load-use stall.
    step(); drive(1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("lw_stall", 4'b1101, 2'b00, 2'b00, 1'b0, 0, 0);
    step(); idle();
    expect_out("lw_cnt", 4'b0000, 2'b00, 2'b00, 1'b0, 1, 0);
    step(); drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("lw_x0", 4'b0000, 2'b00, 2'b00, 1'b0, 1, 0);
    step(); drive(1'b0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("not_load", 4'b0000, 2'b00, 2'b00, 1'b0, 1, 0);
    step(); drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("clr", 4'b0000, 2'b00, 2'b00, 1'b0, 1, 0);

    // Load-use together with a taken branch for three cycles.
    for (int k = 0; k < 3; k++) begin
      step(); load_use(1'b0, 1'b1, 1'b0);
      expect_out("lw_and_branch", 4'b1111, 2'b00, 2'b00, 1'b0, k, k);
    end
    step(); idle();
    expect_out("lw_branch_cnt", 4'b0000, 2'b00, 2'b00, 1'b0, 3, 3);
    step(); load_use(1'b0, 1'b1, 1'b1);
    expect_out("clr_vs_hazard", 4'b1111, 2'b00, 2'b00, 1'b0, 3, 3);
    step(); idle();
    expect_out("clr_wins", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);
    step(); drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("branch_only", 4'b0011, 2'b00, 2'b00, 1'b0, 0, 0);
    step(); idle();
    expect_out("branch_cnt", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 1);

    // Saturation of the 4-bit stall counter.
    for (int i = 0; i < 20; i++) begin
      step(); load_use(1'b0, 1'b0, 1'b0);
      expect_out("sat", 4'b1101, 2'b00, 2'b00, 1'b0, (i > 15) ? 15 : i, 1);
    end
    step(); idle();
    expect_out("sat_hold", 4'b0000, 2'b00, 2'b00, 1'b0, 15, 1);

    // Asynchronous reset between edges in the middle of a stall.
    step(); load_use(1'b0, 1'b0, 1'b0);
    expect_out("mid_stall", 4'b1101, 2'b00, 2'b00, 1'b0, 15, 1);
    step(); load_use(1'b1, 1'b0, 1'b0);
    expect_out("async_rst", 4'b1111, 2'b00, 2'b00, 1'b1, 0, 0);
    for (int j = 0; j < 4; j++) begin
      step(); idle();
      expect_out("reinit", 4'b1111, 2'b00, 2'b00, 1'b1, 0, 0);
    end
    step(); idle();
    expect_out("rerun_idle", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);
    step(); load_use(1'b0, 1'b0, 1'b0);
    expect_out("rerun_lw", 4'b1101, 2'b00, 2'b00, 1'b0, 0, 0);
    step(); idle();
    expect_out("rerun_cnt", 4'b0000, 2'b00, 2'b00, 1'b0, 1, 0);

    stim_done = 1'b1;
  end

endmodule
